kontroler_przerwan: RTL and testbench

- Interrupt controller feeding the instruction decoder's `jest_przerwanie` / `int_vec` inputs.
- Latches rising edges from N peripheral sources (timer flag, pin changes) into a pending register and applies a mask and the global enable (GIE).
- GIE is driven by the decoder's `int_en` / `int_dis`.
- Issues one request at a time at an instruction boundary, then holds off further requests until the handler executes RETI.

---
 rtl/kontroler_przerwan_pkg.sv | 31 +++
 rtl/kontroler_przerwan_priorytet_enkoder.sv | 34 +++
 rtl/kontroler_przerwan.sv | 153 +++++++++++++++
 tb/tb_kontroler_przerwan.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/kontroler_przerwan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : przerwania_pkg
//  Description : Shared types and helpers for the interrupt controller:
//                FSM state type, exception vector constant and the
//                vector-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package przerwania_pkg;

   // Controller FSM: waiting, announcing a request, handler running
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ZGLOSZENIE = 2'd1,
      OBSLUGA    = 2'd2
   } stan_t;

   // Address reserved for the decoder's exception entry
   localparam logic [7:0] c_WEKTOR_WYJATKU = 8'h06;

   // Vector of source i: base + i*step, wrapping modulo 256
   function automatic logic [7:0] wektor(input logic [7:0]  baza,
                                         input logic [7:0]  krok,
                                         input int unsigned i);
      logic [31:0] w_suma;
      w_suma = 32'(baza) + 32'(i) * 32'(krok);
      return w_suma[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/kontroler_przerwan_priorytet_enkoder.sv
`default_nettype none
// ============================================================================
//  Module      : priorytet_enkoder
//  Description : Combinational fixed-priority encoder; the lowest set bit of
//                the candidate vector wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module priorytet_enkoder #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_cand,
   output logic          o_valid,
   output logic [IW-1:0] o_index,
   output logic [N-1:0]  o_onehot
);

   // Scan from the top down so that the lowest index overrides the rest
   always_comb begin
      o_valid  = 1'b0;
      o_index  = '0;
      o_onehot = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_cand[i]) begin
            o_valid     = 1'b1;
            o_index     = IW'(i);
            o_onehot    = '0;
            o_onehot[i] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/kontroler_przerwan.sv
`default_nettype none
// ============================================================================
//  Module      : kontroler_przerwan
//  Description : Interrupt controller. Latches rising edges of the sources
//                into a pending register, applies mask and GIE, and hands
//                one request at a time to the instruction decoder, holding
//                further requests off until the handler returns (RETI).
//  Revision    : 1.0 - initial release
// ============================================================================
module kontroler_przerwan
   import przerwania_pkg::*;
#(
   parameter int         N_ZRODEL = 4,
   parameter logic [7:0] VEC_BASE = 8'h10,
   parameter logic [7:0] VEC_STEP = 8'h02
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_ZRODEL-1:0] irq_src,
   input  logic                maska_wr,
   input  logic [N_ZRODEL-1:0] maska_dane,
   input  logic                int_en,
   input  logic                int_dis,
   input  logic                reti,
   input  logic                gotowy,
   input  logic                stos_pc_full,
   output logic                jest_przerwanie,
   output logic [7:0]          int_vec,
   output logic                gie,
   output logic [N_ZRODEL-1:0] pending,
   output logic [N_ZRODEL-1:0] w_obsludze
);

   localparam int c_IW = (N_ZRODEL > 1) ? $clog2(N_ZRODEL) : 1;

   // Elaboration-time parameter sanity checks
   generate
      if (N_ZRODEL < 1 || N_ZRODEL > 8) begin : g_zla_liczba_zrodel
         $error("kontroler_przerwan: N_ZRODEL must be in 1..8");
      end
      for (genvar gi = 0; gi < N_ZRODEL; gi++) begin : g_sprawdz_wektor
         if (wektor(VEC_BASE, VEC_STEP, gi) == c_WEKTOR_WYJATKU) begin : g_kolizja
            $error("kontroler_przerwan: a source vector equals the exception address");
         end
      end
   endgenerate

   logic [N_ZRODEL-1:0] r_prev_src;
   logic [N_ZRODEL-1:0] r_pending;
   logic [N_ZRODEL-1:0] r_maska;
   logic [N_ZRODEL-1:0] r_w_obsludze;
   logic [N_ZRODEL-1:0] r_onehot;
   logic                r_gie;
   logic                r_jest_przerwanie;
   logic [7:0]          r_int_vec;
   stan_t               r_stan;

   logic [N_ZRODEL-1:0] w_edge;
   logic [N_ZRODEL-1:0] w_cand;
   logic [N_ZRODEL-1:0] w_onehot;
   logic [N_ZRODEL-1:0] w_clr;
   logic [c_IW-1:0]     w_index;
   logic                w_valid;
   logic                w_grant;

   assign w_edge = irq_src & ~r_prev_src;
   assign w_cand = r_pending & r_maska;

   priorytet_enkoder #(
      .N  (N_ZRODEL),
      .IW (c_IW)
   ) u_enkoder (
      .i_cand   (w_cand),
      .o_valid  (w_valid),
      .o_index  (w_index),
      .o_onehot (w_onehot)
   );

   // A grant needs an idle controller at an instruction boundary with room on
   // the PC stack; a simultaneous CLI from the decoder vetoes it
   assign w_grant = (r_stan == IDLE) & r_gie & w_valid & gotowy
                    & ~stos_pc_full & ~int_dis;
   assign w_clr   = w_grant ? w_onehot : '0;

   // Edge capture, pending/mask registers and global enable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_src <= '0;
         r_pending  <= '0;
         r_maska    <= '0;
         r_gie      <= 1'b0;
      end else begin
         r_prev_src <= irq_src;
         // set has priority so an edge during acknowledge is not lost
         r_pending  <= (r_pending & ~w_clr) | w_edge;
         if (maska_wr) begin
            r_maska <= maska_dane;
         end
         // clears (decoder CLI or our own acknowledge) beat SEI
         if (int_dis || (r_stan == ZGLOSZENIE)) begin
            r_gie <= 1'b0;
         end else if (int_en) begin
            r_gie <= 1'b1;
         end
      end
   end

   // Request FSM with registered request pulse, vector and in-service flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stan            <= IDLE;
         r_jest_przerwanie <= 1'b0;
         r_int_vec         <= 8'h00;
         r_onehot          <= '0;
         r_w_obsludze      <= '0;
      end else begin
         case (r_stan)
            IDLE: begin
               if (w_grant) begin
                  r_stan            <= ZGLOSZENIE;
                  r_jest_przerwanie <= 1'b1;
                  r_int_vec         <= wektor(VEC_BASE, VEC_STEP, 32'(w_index));
                  r_onehot          <= w_onehot;
               end
            end
            ZGLOSZENIE: begin
               r_jest_przerwanie <= 1'b0;
               r_w_obsludze      <= r_onehot;
               r_stan            <= OBSLUGA;
            end
            OBSLUGA: begin
               // no nesting: SEI inside the handler only touches GIE
               if (reti) begin
                  r_w_obsludze <= '0;
                  r_stan       <= IDLE;
               end
            end
            default: begin
               r_stan            <= IDLE;
               r_jest_przerwanie <= 1'b0;
            end
         endcase
      end
   end

   assign jest_przerwanie = r_jest_przerwanie;
   assign int_vec         = r_int_vec;
   assign gie             = r_gie;
   assign pending         = r_pending;
   assign w_obsludze      = r_w_obsludze;

endmodule
`default_nettype wire

// File: tb/tb_kontroler_przerwan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kontroler_przerwan
//  Description : Randomized self-checking bench for kontroler_przerwan with
//                a behavioural model and a request scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kontroler_przerwan;

   localparam int         N     = 4;
   localparam logic [7:0] BASE  = 8'h10;
   localparam logic [7:0] STEP  = 8'h02;
   localparam int         NCYC  = 4000;

   logic         clk;
   logic         rst;
   logic [N-1:0] irq_src;
   logic         maska_wr;
   logic [N-1:0] maska_dane;
   logic         int_en;
   logic         int_dis;
   logic         reti;
   logic         gotowy;
   logic         stos_pc_full;
   logic         jest_przerwanie;
   logic [7:0]   int_vec;
   logic         gie;
   logic [N-1:0] pending;
   logic [N-1:0] w_obsludze;

   kontroler_przerwan #(
      .N_ZRODEL (N),
      .VEC_BASE (BASE),
      .VEC_STEP (STEP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .irq_src         (irq_src),
      .maska_wr        (maska_wr),
      .maska_dane      (maska_dane),
      .int_en          (int_en),
      .int_dis         (int_dis),
      .reti            (reti),
      .gotowy          (gotowy),
      .stos_pc_full    (stos_pc_full),
      .jest_przerwanie (jest_przerwanie),
      .int_vec         (int_vec),
      .gie             (gie),
      .pending         (pending),
      .w_obsludze      (w_obsludze)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] pend;
      logic         gie;
      logic [N-1:0] svc;
      logic         jest;
      logic [7:0]   vec;
   } obraz_t;

   obraz_t     q_stat[$];
   logic [7:0] q_vec[$];

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_pulse = 0;

   // Reference model: pending flags, mask, GIE, the source in service
   // (-1 = none) and whether a request is being shown to the decoder
   bit [N-1:0] m_prev, m_pend, m_mask;
   bit         m_gie;
   int         m_svc;
   bit         m_req;
   int         m_req_k;
   logic [7:0] m_vec;

   function automatic obraz_t model_obraz();
      obraz_t o;
      o.pend = m_pend;
      o.gie  = m_gie;
      o.svc  = '0;
      for (int i = 0; i < N; i++) if (m_svc == i) o.svc[i] = 1'b1;
      o.jest = m_req;
      o.vec  = m_vec;
      return o;
   endfunction

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      int      k;
      bit      grant;
      bit [N-1:0] nowe;
      if (rst) begin
         m_prev = '0; m_pend = '0; m_mask = '0; m_gie = 0;
         m_svc = -1; m_req = 0; m_req_k = 0; m_vec = 8'h00;
         return;
      end
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) k = i;
      grant = !m_req && (m_svc < 0) && m_gie && (k >= 0) && gotowy
              && !stos_pc_full && !int_dis;
      for (int i = 0; i < N; i++) begin
         nowe[i] = (irq_src[i] && !m_prev[i]) || (m_pend[i] && !(grant && k == i));
      end
      if (int_dis || m_req) m_gie = 0;
      else if (int_en)      m_gie = 1;
      if (m_req) begin
         m_svc = m_req_k;
         m_req = 0;
      end else if (m_svc >= 0 && reti) begin
         m_svc = -1;
      end
      if (grant) begin
         m_req   = 1;
         m_req_k = k;
         m_vec   = 8'((int'(BASE) + k * int'(STEP)) % 256);
         q_vec.push_back(m_vec);
      end
      m_pend = nowe;
      if (maska_wr) m_mask = maska_dane;
      m_prev = irq_src;
   endtask

   // Monitor: compare visible state every cycle, and each request pulse
   // against the scoreboard of granted vectors
   always @(negedge clk) begin
      obraz_t exp_o, act_o;
      logic [7:0] v;
      if (q_stat.size() > 0) begin
         exp_o = q_stat.pop_front();
         act_o = {pending, gie, w_obsludze, jest_przerwanie, int_vec};
         n_cmp++;
         if (act_o !== exp_o) begin
            n_bad++;
            $display("FAIL status t=%0t got pend=%b gie=%b svc=%b req=%b vec=%h expected pend=%b gie=%b svc=%b req=%b vec=%h",
                     $time, act_o.pend, act_o.gie, act_o.svc, act_o.jest, act_o.vec,
                     exp_o.pend, exp_o.gie, exp_o.svc, exp_o.jest, exp_o.vec);
         end
      end
      if (jest_przerwanie === 1'b1) begin
         n_pulse++;
         n_cmp++;
         if (q_vec.size() == 0) begin
            n_bad++;
            $display("FAIL request t=%0t got unexpected request vec=%h expected none", $time, int_vec);
         end else begin
            v = q_vec.pop_front();
            if (int_vec !== v) begin
               n_bad++;
               $display("FAIL request_vec t=%0t got %h expected %h", $time, int_vec, v);
            end
         end
      end
   end

   // Stimulus: random decoder/peripheral activity with occasional resets
   initial begin
      m_svc = -1;
      rst = 1'b1; irq_src = '0; maska_wr = 1'b0; maska_dane = '0;
      int_en = 1'b0; int_dis = 1'b0; reti = 1'b0; gotowy = 1'b0; stos_pc_full = 1'b0;
      model_step();
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         q_stat.push_back(model_obraz());
         rst = (c < 2) || ($urandom_range(0, 499) == 0);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
         maska_wr   = ($urandom_range(0, 19) == 0);
         maska_dane = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         reti       = ($urandom_range(0, 7) == 0);
         int_en     = reti || ($urandom_range(0, 5) == 0);
         int_dis    = ($urandom_range(0, 24) == 0);
         gotowy     = ($urandom_range(0, 4) != 0) && (c < NCYC - 4);
         stos_pc_full = ($urandom_range(0, 9) == 0);
         model_step();
      end
      @(posedge clk);
      #1;
      q_stat.push_back(model_obraz());
      repeat (3) @(negedge clk);
      n_cmp++;
      if (q_vec.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_requests got %0d outstanding expected 0", q_vec.size());
      end
      n_cmp++;
      if (n_pulse < 20) begin
         n_bad++;
         $display("FAIL request_count got %0d pulses expected at least 20", n_pulse);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
